// File: rtl/mac_seq_ctrl.sv
// Sequencer for a single signed multiply-accumulate unit: clears the accumulator,
// streams len operand pairs, waits out the pipeline and offers the sum on valid/ready.
module mac_seq_ctrl #(
  parameter int ADDR_BIT = 10,
  parameter int LEN_BIT  = 10,
  parameter int OUT_BIT  = 20,
  parameter int RD_LAT   = 1,
  parameter int MAC_LAT  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [LEN_BIT-1:0]  len_i,
  input  logic [ADDR_BIT-1:0] in_base_i,
  input  logic [ADDR_BIT-1:0] w_base_i,
  output logic                busy_o,
  output logic                rd_en_o,
  output logic [ADDR_BIT-1:0] in_addr_o,
  output logic [ADDR_BIT-1:0] w_addr_o,
  output logic                mac_clr_o,
  output logic                mac_ena_o,
  input  logic [OUT_BIT-1:0]  mac_result_i,
  output logic [OUT_BIT-1:0]  sum_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam int DRAIN_CYC = RD_LAT + MAC_LAT;
  localparam int CNT_BIT   = (LEN_BIT > 4) ? LEN_BIT : 4;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_BIT-1:0]  cnt_q, cnt_d;
  logic [ADDR_BIT-1:0] in_base_q, in_base_d, w_base_q, w_base_d;
  logic [ADDR_BIT-1:0] in_addr_q, in_addr_d, w_addr_q, w_addr_d;
  logic [OUT_BIT-1:0]  sum_q, sum_d;
  logic [RD_LAT-1:0]   ena_pipe_q;
  logic                cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_base_q  <= '0;
      w_base_q   <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      sum_q      <= '0;
      ena_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_base_q  <= in_base_d;
      w_base_q   <= w_base_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      sum_q      <= sum_d;
      // mac_ena is rd_en aligned with the operand buffers' read data
      ena_pipe_q <= RD_LAT'({ena_pipe_q, rd_en_o});
    end
  end

  // cnt_q counts down the remaining FEED cycles, then the remaining DRAIN cycles
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_base_d = in_base_q;
    w_base_d  = w_base_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    sum_d     = sum_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d   = CLEAR;
          cnt_d     = CNT_BIT'(len_i) - CNT_BIT'(1);
          in_base_d = in_base_i;
          w_base_d  = w_base_i;
        end
      end
      CLEAR: begin
        state_d   = FEED;
        in_addr_d = in_base_q;
        w_addr_d  = w_base_q;
      end
      FEED: begin
        if (cnt_zero) begin
          state_d = DRAIN;
          cnt_d   = CNT_BIT'(DRAIN_CYC - 1);
        end else begin
          cnt_d     = cnt_q - CNT_BIT'(1);
          in_addr_d = in_addr_q + ADDR_BIT'(1);
          w_addr_d  = w_addr_q + ADDR_BIT'(1);
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_d = HOLD;
          sum_d   = mac_result_i;
        end else begin
          cnt_d = cnt_q - CNT_BIT'(1);
        end
      end
      HOLD: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    rd_en_o     = (state_q == FEED);
    mac_clr_o   = rst_i || (state_q == CLEAR);
    out_valid_o = (state_q == HOLD);
  end

  assign in_addr_o = in_addr_q;
  assign w_addr_o  = w_addr_q;
  assign sum_o     = sum_q;
  assign mac_ena_o = ena_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: two instances (default latencies and RD_LAT=3/MAC_LAT=1),
// each with behavioural operand buffers and MAC; jobs checked against dot products and cycle formulas.
module tb_mac_seq_ctrl;

  localparam int ADDR_BIT  = 10;
  localparam int LEN_BIT   = 10;
  localparam int OUT_BIT   = 20;
  localparam int DEPTH     = 1 << ADDR_BIT;
  localparam int RD_LAT_A  = 1;
  localparam int MAC_LAT_A = 4;
  localparam int RD_LAT_B  = 3;
  localparam int MAC_LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                startV     [2];
  logic [LEN_BIT-1:0]  lenV       [2];
  logic [ADDR_BIT-1:0] inBaseV    [2];
  logic [ADDR_BIT-1:0] wBaseV     [2];
  logic                outReadyV  [2];
  logic                busyV      [2];
  logic                rdEnV      [2];
  logic                macClrV    [2];
  logic                macEnaV    [2];
  logic                outValidV  [2];
  logic [ADDR_BIT-1:0] inAddrV    [2];
  logic [ADDR_BIT-1:0] wAddrV     [2];
  logic [OUT_BIT-1:0]  sumV       [2];

  logic signed [OUT_BIT-1:0] inMem [DEPTH];
  logic signed [OUT_BIT-1:0] wMem  [DEPTH];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int RL = (g == 0) ? RD_LAT_A : RD_LAT_B;
    localparam int ML = (g == 0) ? MAC_LAT_A : MAC_LAT_B;

    logic                      busy, rdEn, macClr, macEna, outValid;
    logic [ADDR_BIT-1:0]       inAddr, wAddr;
    logic [OUT_BIT-1:0]        sum, macResult;
    logic [ADDR_BIT-1:0]       inPipe [RL];
    logic [ADDR_BIT-1:0]       wPipe  [RL];
    logic signed [OUT_BIT-1:0] inData, wData, prod, acc;
    logic signed [OUT_BIT-1:0] prodPipe [ML];

    mac_seq_ctrl #(
      .ADDR_BIT(ADDR_BIT), .LEN_BIT(LEN_BIT), .OUT_BIT(OUT_BIT),
      .RD_LAT(RL), .MAC_LAT(ML)
    ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(startV[g]), .len_i(lenV[g]),
      .in_base_i(inBaseV[g]), .w_base_i(wBaseV[g]), .busy_o(busy),
      .rd_en_o(rdEn), .in_addr_o(inAddr), .w_addr_o(wAddr),
      .mac_clr_o(macClr), .mac_ena_o(macEna), .mac_result_i(macResult),
      .sum_o(sum), .out_valid_o(outValid), .out_ready_i(outReadyV[g])
    );

    // Operand buffers deliver mem[addr] RL cycles after the address is presented
    assign inData    = inMem[inPipe[RL-1]];
    assign wData     = wMem[wPipe[RL-1]];
    assign prod      = inData * wData;
    assign macResult = acc + prodPipe[ML-1];

    // A product enabled in cycle c shows up in macResult in cycle c+ML
    always @(posedge clk) begin
      inPipe[0] <= inAddr;
      wPipe[0]  <= wAddr;
      for (int i = 1; i < RL; i++) begin
        inPipe[i] <= inPipe[i-1];
        wPipe[i]  <= wPipe[i-1];
      end
      if (macClr) begin
        acc <= '0;
        for (int i = 0; i < ML; i++) prodPipe[i] <= '0;
      end else begin
        acc         <= acc + prodPipe[ML-1];
        prodPipe[0] <= macEna ? prod : '0;
        for (int i = 1; i < ML; i++) prodPipe[i] <= prodPipe[i-1];
      end
    end

    assign busyV[g]     = busy;
    assign rdEnV[g]     = rdEn;
    assign macClrV[g]   = macClr;
    assign macEnaV[g]   = macEna;
    assign outValidV[g] = outValid;
    assign inAddrV[g]   = inAddr;
    assign wAddrV[g]    = wAddr;
    assign sumV[g]      = sum;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input int g, input string tag);
    checkOutput($sformatf("g%0d %s busy", g, tag), 32'(busyV[g]), 32'd0);
    checkOutput($sformatf("g%0d %s rdEn", g, tag), 32'(rdEnV[g]), 32'd0);
    checkOutput($sformatf("g%0d %s macEna", g, tag), 32'(macEnaV[g]), 32'd0);
    checkOutput($sformatf("g%0d %s outValid", g, tag), 32'(outValidV[g]), 32'd0);
  endtask

  // Called on a negedge in an IDLE cycle; returns on the negedge of the first IDLE cycle after the job
  task automatic applyStimulus(input int g, input int n, input logic [ADDR_BIT-1:0] ib,
                               input logic [ADDR_BIT-1:0] wb, input int holdCyc, input bit pokeHold);
    int rl, d, acc, enaCnt;
    logic [ADDR_BIT-1:0] ea, eb;
    logic [OUT_BIT-1:0] expSum;
    rl  = (g == 0) ? RD_LAT_A : RD_LAT_B;
    d   = rl + ((g == 0) ? MAC_LAT_A : MAC_LAT_B);
    acc = 0;
    for (int k = 0; k < n; k++) begin
      ea  = ib + ADDR_BIT'(k);
      eb  = wb + ADDR_BIT'(k);
      acc += int'(inMem[ea]) * int'(wMem[eb]);
    end
    expSum = OUT_BIT'(acc);
    enaCnt = 0;
    startV[g] = 1'b1; lenV[g] = LEN_BIT'(n); inBaseV[g] = ib; wBaseV[g] = wb;
    for (int o = 1; o <= 1 + n + d; o++) begin
      @(negedge clk);
      startV[g] = 1'b0;
      lenV[g] = LEN_BIT'($urandom); inBaseV[g] = ADDR_BIT'($urandom); wBaseV[g] = ADDR_BIT'($urandom);
      if (macEnaV[g]) enaCnt++;
      checkOutput($sformatf("g%0d o%0d busy", g, o), 32'(busyV[g]), 32'd1);
      checkOutput($sformatf("g%0d o%0d macClr", g, o), 32'(macClrV[g]), 32'(o == 1));
      checkOutput($sformatf("g%0d o%0d rdEn", g, o), 32'(rdEnV[g]), 32'(o >= 2 && o <= 1 + n));
      checkOutput($sformatf("g%0d o%0d macEna", g, o), 32'(macEnaV[g]),
                  32'(o >= 2 + rl && o <= 1 + n + rl));
      checkOutput($sformatf("g%0d o%0d outValid", g, o), 32'(outValidV[g]), 32'd0);
      if (o >= 2) begin
        ea = ib + ADDR_BIT'((o <= 1 + n) ? o - 2 : n - 1);
        eb = wb + ADDR_BIT'((o <= 1 + n) ? o - 2 : n - 1);
        checkOutput($sformatf("g%0d o%0d inAddr", g, o), 32'(inAddrV[g]), 32'(ea));
        checkOutput($sformatf("g%0d o%0d wAddr", g, o), 32'(wAddrV[g]), 32'(eb));
      end
      outReadyV[g] = (o < 1 + n + d) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    for (int h = 0; h <= holdCyc; h++) begin
      @(negedge clk);
      startV[g] = 1'b0;
      checkOutput($sformatf("g%0d h%0d outValid", g, h), 32'(outValidV[g]), 32'd1);
      checkOutput($sformatf("g%0d h%0d sum", g, h), 32'(sumV[g]), 32'(expSum));
      checkOutput($sformatf("g%0d h%0d busy", g, h), 32'(busyV[g]), 32'd1);
      checkOutput($sformatf("g%0d h%0d rdEn", g, h), 32'(rdEnV[g]), 32'd0);
      if (pokeHold && h == holdCyc / 2) begin
        startV[g] = 1'b1; lenV[g] = LEN_BIT'($urandom_range(1, 9));
      end
    end
    checkOutput($sformatf("g%0d enaCnt", g), 32'(enaCnt), 32'(n));
    outReadyV[g] = 1'b1;
    if (pokeHold) begin
      startV[g] = 1'b1; lenV[g] = LEN_BIT'($urandom_range(1, 9));
    end
    @(negedge clk);
    outReadyV[g] = 1'b0;
    startV[g] = 1'b0;
    checkIdle(g, "release");
    checkOutput($sformatf("g%0d release macClr", g), 32'(macClrV[g]), 32'd0);
  endtask

  task automatic lenZeroStart(input int g);
    startV[g] = 1'b1; lenV[g] = '0; inBaseV[g] = ADDR_BIT'($urandom); wBaseV[g] = ADDR_BIT'($urandom);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      startV[g] = 1'b0;
      checkIdle(g, $sformatf("len0 c%0d", c));
      checkOutput($sformatf("g%0d len0 c%0d macClr", g, c), 32'(macClrV[g]), 32'd0);
    end
  endtask

  task automatic resetMidJob();
    startV[0] = 1'b1; lenV[0] = 10'd8; inBaseV[0] = 10'h123; wBaseV[0] = 10'h321;
    for (int o = 1; o <= 4; o++) begin
      @(negedge clk);
      startV[0] = 1'b0;
    end
    checkOutput("rstJob feed rdEn", 32'(rdEnV[0]), 32'd1);
    checkOutput("rstJob feed inAddr", 32'(inAddrV[0]), 32'h125);
    rst = 1'b1;
    @(negedge clk);
    checkIdle(0, "rstJob after");
    checkOutput("rstJob macClr", 32'(macClrV[0]), 32'd1);
    checkOutput("rstJob inAddr", 32'(inAddrV[0]), 32'd0);
    checkOutput("rstJob wAddr", 32'(wAddrV[0]), 32'd0);
    checkOutput("rstJob sum", 32'(sumV[0]), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkIdle(0, $sformatf("rstJob quiet c%0d", c));
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      startV[g] = 1'b0; lenV[g] = '0; inBaseV[g] = '0; wBaseV[g] = '0; outReadyV[g] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      inMem[i] = OUT_BIT'(int'($urandom_range(0, 255)) - 128);
      wMem[i]  = OUT_BIT'(int'($urandom_range(0, 255)) - 128);
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkIdle(g, "reset");
      checkOutput($sformatf("g%0d reset macClr", g), 32'(macClrV[g]), 32'd1);
      checkOutput($sformatf("g%0d reset inAddr", g), 32'(inAddrV[g]), 32'd0);
      checkOutput($sformatf("g%0d reset sum", g), 32'(sumV[g]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset macClr", 32'(macClrV[0]), 32'd0);

    $display("[TB] basic dot product");
    inMem[10'h010] = 2;  inMem[10'h011] = -3; inMem[10'h012] = 4;
    wMem[10'h200]  = 5;  wMem[10'h201]  = 6;  wMem[10'h202]  = -7;
    applyStimulus(0, 3, 10'h010, 10'h200, 3, 1'b0);

    $display("[TB] zero-length start");
    lenZeroStart(0);

    $display("[TB] address wrap");
    applyStimulus(0, 4, 10'h3FE, 10'h3FD, 0, 1'b0);

    $display("[TB] long hold, start ignored in HOLD, back-to-back job");
    applyStimulus(0, 6, ADDR_BIT'($urandom), ADDR_BIT'($urandom), 20, 1'b1);
    applyStimulus(0, 2, ADDR_BIT'($urandom), ADDR_BIT'($urandom), 0, 1'b0);

    $display("[TB] reset during FEED");
    resetMidJob();
    inMem[10'h050] = 1; wMem[10'h060] = 1;
    applyStimulus(0, 1, 10'h050, 10'h060, 1, 1'b0);

    $display("[TB] RD_LAT=3 MAC_LAT=1 instance");
    applyStimulus(1, 5, ADDR_BIT'($urandom), ADDR_BIT'($urandom), 2, 1'b0);

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      applyStimulus(j % 2, int'($urandom_range(1, 24)), ADDR_BIT'($urandom), ADDR_BIT'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for one signed multiply-accumulate unit (one multiply-add pipeline, result OUT_BIT wide).
- Per job:
  - clears the accumulator;
  - streams LEN operand pairs from an input-feature buffer and a weight buffer;
  - waits out the read and MAC pipeline latency;
  - presents the final accumulated sum on a valid/ready output.
- Sits between the layer scheduler (issues start/len/base addresses) and the MAC plus its two operand memories.

Parameters:
- ADDR_BIT, 10, width of input and weight buffer addresses.
- LEN_BIT, 10, width of the job length field.
- OUT_BIT, 20, width of the MAC result and captured sum.
- RD_LAT, 1, read latency of both operand buffers in cycles (rd_en to data valid), range 1..4.
- MAC_LAT, 4, cycles from a MAC enable cycle until that product is reflected in the MAC result, range 1..8.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  job request pulse, sampled only in IDLE.
- len  in  LEN_BIT  number of operand pairs, sampled with start.
- in_base  in  ADDR_BIT  first input-buffer address, sampled with start.
- w_base  in  ADDR_BIT  first weight-buffer address, sampled with start.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  read strobe to both operand buffers.
- in_addr  out  ADDR_BIT  input-buffer read address.
- w_addr  out  ADDR_BIT  weight-buffer read address.
- mac_clr  out  1  accumulator synchronous clear to MAC.
- mac_ena  out  1  MAC clock enable (operands valid).
- mac_result  in  OUT_BIT  signed MAC accumulated output.
- sum  out  OUT_BIT  captured signed result.
- out_valid  out  1  sum valid.
- out_ready  in  1  consumer accepts sum.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy = rd_en = mac_ena = out_valid = 0.
  - in_addr = w_addr = 0; sum = 0.
  - mac_clr = 1 while rst is high.
  - mac_ena delay line flushed.
- Reset mid-job: applies the reset values on the next edge; in-flight products are discarded; no out_valid is produced for that job.
- FSM:
  - IDLE: on start=1 and len!=0, latch len, in_base and w_base, then go to CLEAR. start with len=0 is ignored (stay IDLE, no output).
  - CLEAR: one cycle, mac_clr=1, then go to FEED.
  - FEED: exactly len cycles. rd_en=1. In the k-th FEED cycle (k=0..len-1), in_addr = in_base+k and w_addr = w_base+k. After the last one, go to DRAIN.
  - DRAIN: exactly D = RD_LAT+MAC_LAT cycles, rd_en=0. In the last DRAIN cycle, register sum <= mac_result. Then go to HOLD.
  - HOLD: out_valid=1 and sum stable. On out_ready=1, go to IDLE next cycle (out_valid drops). out_ready while out_valid=0 is ignored.
- mac_ena is rd_en delayed by exactly RD_LAT cycles (shift register), so it is high for exactly len cycles per job.
- Address arithmetic: modulo 2^ADDR_BIT; base+k wraps silently past the top address.
- Timing: start sampled at cycle t gives:
  - CLEAR at t+1;
  - FEED t+2..t+1+len;
  - DRAIN t+2+len..t+1+len+D;
  - out_valid first high at t+2+len+D.
- Single outstanding job: start in any non-IDLE state is ignored, including HOLD with out_ready=1 in the same cycle. A new start is accepted on the first IDLE cycle.
- Outside FEED, in_addr and w_addr hold their last value.
- mac_clr is high only in CLEAR or during rst.
- mac_result width and sign are passed through unmodified. Overflow behaviour belongs to the MAC (wraps at OUT_BIT); no saturation here.

Test Plan:
- Reset, then start with len=3, in_base=0x010, w_base=0x200, buffers holding inputs {2,-3,4} and weights {5,6,-7}, MAC model with defaults -> mac_clr high at t+1; rd_en t+2..t+4 with in_addr 0x010..0x012 and w_addr 0x200..0x202; mac_ena t+3..t+5; out_valid at t+10 with sum = -36; holds until out_ready.
- len=0 start -> busy stays 0, no rd_en, no mac_clr, no out_valid.
- in_base=0x3FE, len=4 -> in_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- out_ready held low 20 cycles after out_valid -> sum and out_valid stable throughout; a start pulse during HOLD is ignored; after out_ready, a start on the IDLE cycle launches a new job.
- rst asserted for one cycle during FEED (k=2 of len=8) -> next cycle all outputs at reset values, mac_ena low, no out_valid; a following job with len=1 and operands 1×1 returns sum=1.
- Parameter sweep RD_LAT=3, MAC_LAT=1, len=5 -> mac_ena count = 5; out_valid at t+11; sum matches reference dot product.
